// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control sequencer for the R/I-type ALU datapath. Each
//   instruction walks FETCH -> DECODE -> EXEC -> WB. The block handshakes with
//   instruction memory, strobes the IR/PC write enables, drives ALU control and
//   the register-file write enable, counts retired instructions and traps
//   illegal opcodes and fetch timeouts into a sticky ERROR state.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     begin execution (looked at in IDLE only)
//   stop_i      halt once the current instruction retires
//   Op_i        opcode field from IR (meaningful from DECODE onward)
//   imem_req_o  instruction fetch request (every FETCH cycle)
//   imem_ack_i  fetch data valid this cycle
//   ir_we_o     load IR (same cycle as the ack)
//   pc_we_o     advance PC (WB)
//   ALUOp_o     ALU control, 10 = R-type, 11 = I-type (EXEC/WB only)
//   ALUSrc_o    0 = rs2, 1 = immediate (EXEC/WB only)
//   RegWrite_o  register-file write enable (WB)
//   busy_o      running: neither IDLE nor ERROR
//   illegal_o   sticky illegal-opcode trap
//   timeout_o   sticky fetch-timeout trap
//   retired_o   retired-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter logic [6:0] OP_R          = 7'b0110011,
  parameter logic [6:0] OP_I          = 7'b0010011,
  parameter int         FETCH_TIMEOUT = 16,
  parameter int         CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [6:0]       Op_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired_o
);

  // Wait counter only has to reach FETCH_TIMEOUT-1; keep at least one bit.
  localparam int                WAIT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic [1:0]        aluop_q, aluop_d;
  logic              alusrc_q, alusrc_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic fetch_expired;
  logic op_is_r;
  logic op_is_i;

  assign fetch_expired = (wait_cnt_q == WAIT_LAST);
  assign op_is_r       = (Op_i == OP_R);
  assign op_is_i       = (Op_i == OP_I);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
      aluop_q     <= 2'b00;
      alusrc_q    <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stop_pend_q <= stop_pend_d;
      aluop_q     <= aluop_d;
      alusrc_q    <= alusrc_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      retired_q   <= retired_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack_i)         state_d = S_DECODE;
        else if (fetch_expired) state_d = S_ERROR;
      end
      S_DECODE: state_d = (op_is_r || op_is_i) ? S_EXEC : S_ERROR;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = (stop_pend_q || stop_i) ? S_IDLE : S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values (counters, latched ALU control, sticky traps)
  // -------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    stop_pend_d = stop_pend_q;
    aluop_d     = aluop_q;
    alusrc_d    = alusrc_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    retired_d   = retired_q;

    if (stop_i && (state_q == S_FETCH || state_q == S_DECODE || state_q == S_EXEC))
      stop_pend_d = 1'b1;

    case (state_q)
      S_FETCH: begin
        if (imem_ack_i) begin
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (fetch_expired) timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_is_r) begin
          aluop_d  = 2'b10;
          alusrc_d = 1'b0;
        end else if (op_is_i) begin
          aluop_d  = 2'b11;
          alusrc_d = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      S_WB:    retired_d = retired_q + 1'b1;
      default: ;
    endcase

    // A halt request is consumed by the transition into IDLE.
    if (state_d == S_IDLE) stop_pend_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Output logic (Moore, except ir_we_o which follows the ack)
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    RegWrite_o = 1'b0;
    ALUOp_o    = 2'b00;
    ALUSrc_o   = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ack_i;
        busy_o     = 1'b1;
      end
      S_DECODE: busy_o = 1'b1;
      S_EXEC: begin
        ALUOp_o  = aluop_q;
        ALUSrc_o = alusrc_q;
        busy_o   = 1'b1;
      end
      S_WB: begin
        ALUOp_o    = aluop_q;
        ALUSrc_o   = alusrc_q;
        RegWrite_o = 1'b1;
        pc_we_o    = 1'b1;
        busy_o     = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Bench for multicycle_sequencer. Instructions are described at the
//   transaction level (opcode, ack delay, where a stop request lands); a
//   planner expands each into the per-cycle stimulus and the outputs the
//   instruction must produce. One process applies and checks the plan.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam int         FETCH_TO = 16;
  localparam int         CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [6:0]       op = '0;
  logic             ack = 1'b0;
  logic             imem_req, ir_we, pc_we, alusrc, regwr, busy, illegal, timeout;
  logic [1:0]       aluop;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .OP_R(OP_R), .OP_I(OP_I), .FETCH_TIMEOUT(FETCH_TO), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .Op_i(op),
    .imem_req_o(imem_req), .imem_ack_i(ack), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .ALUOp_o(aluop), .ALUSrc_o(alusrc), .RegWrite_o(regwr), .busy_o(busy),
    .illegal_o(illegal), .timeout_o(timeout), .retired_o(retired)
  );

  typedef struct {
    bit        rst, start, stop, ack;
    bit [6:0]  op;
    bit        req, irwe, wb;
    bit [1:0]  aluop;
    bit        alusrc, busy, ill, to;
    bit [15:0] ret;
  } cyc_t;

  cyc_t plan[$];

  // Architectural-level model state
  bit        m_ill, m_to;
  bit [15:0] m_ret;

  int total = 0;
  int bad   = 0;
  int req_cnt, wb_cnt, i_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic bit r1();
    return 1'($urandom);
  endfunction

  task automatic push(input bit rst_, start_, stop_, ack_, input bit [6:0] op_,
                      input bit req_, irwe_, wb_, input bit [1:0] au_,
                      input bit src_, busy_);
    cyc_t c;
    c.rst = rst_; c.start = start_; c.stop = stop_; c.ack = ack_; c.op = op_;
    c.req = req_; c.irwe = irwe_; c.wb = wb_; c.aluop = au_; c.alusrc = src_;
    c.busy = busy_; c.ill = m_ill; c.to = m_to; c.ret = m_ret;
    plan.push_back(c);
  endtask

  // Reset for n cycles, then one released cycle in IDLE.
  task automatic do_reset(input int n);
    m_ill = 0; m_to = 0; m_ret = 0;
    for (int k = 0; k < n; k++) push(1, r1(), r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
    push(0, 0, r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) push(0, 0, r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic start_cycle();
    push(0, 1, r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
  endtask

  // ERROR ignores everything; the first cycle always carries a start pulse.
  task automatic error_cycles(input int n);
    for (int k = 0; k < n; k++)
      push(0, (k == 0) ? 1'b1 : r1(), r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
  endtask

  // where: 1 fetch, 2 decode, 3 exec, 4 wb; stop_at 5 = random everywhere.
  function automatic bit stp(input int stop_at, input int where, input int k);
    if (stop_at == 5) return ($urandom_range(0, 7) == 0);
    return (stop_at == where) && (k == 0);
  endfunction

  // One instruction starting in FETCH. nxt: 0 FETCH, 1 IDLE, 2 ERROR, 3 reset.
  task automatic instr(input bit [6:0] iop, input int delay, input int stop_at,
                       input bit rst_exec, output int nxt);
    bit       pend = 0;
    bit       s;
    bit       legal;
    bit [1:0] au;
    bit       src;
    for (int k = 0; k < delay && k < FETCH_TO; k++) begin
      s = stp(stop_at, 1, k); pend |= s;
      push(0, r1(), s, 0, r7(), 1, 0, 0, 2'b00, 0, 1);
    end
    if (delay >= FETCH_TO) begin
      m_to = 1; nxt = 2; return;
    end
    s = stp(stop_at, 1, delay); pend |= s;
    push(0, r1(), s, 1, r7(), 1, 1, 0, 2'b00, 0, 1);
    s = stp(stop_at, 2, 0); pend |= s;
    push(0, r1(), s, r1(), iop, 0, 0, 0, 2'b00, 0, 1);
    legal = (iop == OP_R) || (iop == OP_I);
    if (!legal) begin
      m_ill = 1; nxt = 2; return;
    end
    au  = (iop == OP_R) ? 2'b10 : 2'b11;
    src = (iop == OP_I);
    if (rst_exec) begin
      m_ret = 0; m_ill = 0; m_to = 0;
      push(1, r1(), r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
      push(0, 0, r1(), r1(), r7(), 0, 0, 0, 2'b00, 0, 0);
      nxt = 3; return;
    end
    s = stp(stop_at, 3, 0); pend |= s;
    push(0, r1(), s, r1(), r7(), 0, 0, 0, au, src, 1);
    s = stp(stop_at, 4, 0);
    push(0, r1(), s, r1(), r7(), 0, 0, 1, au, src, 1);
    m_ret++;
    nxt = (pend || s) ? 1 : 0;
  endtask

  // Apply planned inputs just after the rising edge, check at the falling edge.
  task automatic run_plan(input string tag);
    cyc_t c;
    int   n = 0;
    req_cnt = 0; wb_cnt = 0; i_cnt = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk); #1;
      rst = c.rst; start = c.start; stop = c.stop; ack = c.ack; op = c.op;
      @(negedge clk);
      n++;
      if (imem_req) req_cnt++;
      if (regwr) wb_cnt++;
      if (aluop == 2'b11) i_cnt++;
      chk("imem_req", 32'(imem_req), 32'(c.req));
      chk("ir_we",    32'(ir_we),    32'(c.irwe));
      chk("pc_we",    32'(pc_we),    32'(c.wb));
      chk("RegWrite", 32'(regwr),    32'(c.wb));
      chk("ALUOp",    32'(aluop),    32'(c.aluop));
      chk("ALUSrc",   32'(alusrc),   32'(c.alusrc));
      chk("busy",     32'(busy),     32'(c.busy));
      chk("illegal",  32'(illegal),  32'(c.ill));
      chk("timeout",  32'(timeout),  32'(c.to));
      chk("retired",  32'(retired),  32'(c.ret));
    end
    $display("segment %s: %0d cycles, req=%0d wb=%0d retired=%0d", tag, n, req_cnt, wb_cnt, retired);
  endtask

  initial begin
    int       nxt;
    int       r;
    int       delay;
    bit [6:0] iop;

    // 1: single R op, same-cycle ack
    do_reset(2); start_cycle(); instr(OP_R, 0, 4, 0, nxt); idle_cycles(1);
    run_plan("t1_r_op");
    chk("t1_req_cycles", 32'(req_cnt), 32'd1);
    chk("t1_wb_pulses",  32'(wb_cnt),  32'd1);
    chk("t1_retired",    32'(retired), 32'd1);

    // 2: I op, ack three cycles late
    do_reset(1); start_cycle(); instr(OP_I, 3, 4, 0, nxt); idle_cycles(1);
    run_plan("t2_i_op_delay3");
    chk("t2_req_cycles",  32'(req_cnt), 32'd4);
    chk("t2_itype_cycles", 32'(i_cnt),  32'd2);
    chk("t2_retired",     32'(retired), 32'd1);

    // 3: illegal opcode, start pulse in ERROR ignored
    do_reset(1); start_cycle(); instr(7'b0000011, 0, 0, 0, nxt); error_cycles(4);
    run_plan("t3_illegal");
    chk("t3_illegal", 32'(illegal), 32'd1);
    chk("t3_busy",    32'(busy),    32'd0);
    chk("t3_wb",      32'(wb_cnt),  32'd0);
    chk("t3_retired", 32'(retired), 32'd0);

    // 4: never acked
    do_reset(1); start_cycle(); instr(OP_R, 100, 0, 0, nxt); error_cycles(3);
    run_plan("t4_timeout");
    chk("t4_req_cycles", 32'(req_cnt), 32'd16);
    chk("t4_timeout",    32'(timeout), 32'd1);
    chk("t4_busy",       32'(busy),    32'd0);

    // 5: back-to-back R ops, stop in the second EXEC
    do_reset(1); start_cycle();
    instr(OP_R, 0, 0, 0, nxt); instr(OP_R, 0, 3, 0, nxt); idle_cycles(2);
    run_plan("t5_stop");
    chk("t5_retired", 32'(retired), 32'd2);
    chk("t5_wb",      32'(wb_cnt),  32'd2);
    chk("t5_busy",    32'(busy),    32'd0);

    // 6: reset in the middle of EXEC, then recover
    do_reset(1); start_cycle();
    instr(OP_R, 0, 0, 0, nxt); instr(OP_R, 1, 0, 1, nxt);
    run_plan("t6_reset_exec");
    chk("t6_retired", 32'(retired), 32'd0);
    chk("t6_busy",    32'(busy),    32'd0);
    start_cycle(); instr(OP_I, 0, 4, 0, nxt); idle_cycles(1);
    run_plan("t6_recover");
    chk("t6_retired_after", 32'(retired), 32'd1);

    // Randomized programs
    do_reset(1);
    for (int p = 0; p < 150; p++) begin
      start_cycle();
      nxt = 0;
      while (nxt == 0) begin
        r = $urandom_range(0, 9);
        iop = (r < 5) ? OP_R : (r < 9) ? OP_I : r7();
        r = $urandom_range(0, 15);
        delay = (r == 0) ? FETCH_TO + $urandom_range(0, 3) :
                (r == 1) ? FETCH_TO - 1 : $urandom_range(0, 3);
        instr(iop, delay, 5, 0, nxt);
      end
      if (nxt == 1) idle_cycles($urandom_range(0, 3));
      else begin
        error_cycles(2);
        do_reset(1);
      end
      run_plan($sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
